// File: rtl/gsim_pkg.sv
// gsim_pkg: shared definitions for the GSIM residual checker.
// Holds the problem size, the band coefficients of the system matrix,
// the datapath widths, the checker state enum and the tolerance test.
package gsim_pkg;

  localparam int N     = 16;
  localparam int B_W   = 16;
  localparam int X_W   = 32;
  localparam int ACC_W = 39;
  localparam int R_W   = 40;
  localparam int FRAC  = 16;

  // Band of the symmetric matrix: diagonal, then distance 1, 2, 3.
  localparam int COEF_D = 20;
  localparam int COEF_1 = -13;
  localparam int COEF_2 = 6;
  localparam int COEF_3 = -1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CALC    = 2'd1,
    DONE    = 2'd2
  } state_t;

  // True when |r| is strictly larger than the unsigned tolerance.
  function automatic logic exceeds_tol(input logic signed [ACC_W-1:0] r,
                                       input logic [31:0] tol);
    logic signed [ACC_W-1:0] t;
    t = {{(ACC_W-32){1'b0}}, tol};
    return (r > t) || (r < -t);
  endfunction

endpackage

// File: rtl/gsim_band_row.sv
// gsim_band_row: combinational product of one matrix row with the
// seven x values around the diagonal (x_m3 .. x_p3). Values outside the
// matrix must be zero-filled by the caller.
// Ports:
//   x_m3..x_p3 : signed Q16.16 solution elements k-3 .. k+3
//   row_sum    : signed 39-bit (M*x)[k] in Q16.16
// Coefficients are realised with shifts and adds only, using the
// symmetry of the band to add mirrored neighbours before scaling.
module gsim_band_row
  import gsim_pkg::*;
(
  input  logic signed [X_W-1:0]   x_m3,
  input  logic signed [X_W-1:0]   x_m2,
  input  logic signed [X_W-1:0]   x_m1,
  input  logic signed [X_W-1:0]   x_c,
  input  logic signed [X_W-1:0]   x_p1,
  input  logic signed [X_W-1:0]   x_p2,
  input  logic signed [X_W-1:0]   x_p3,
  output logic signed [ACC_W-1:0] row_sum
);

  logic signed [ACC_W-1:0] e_c;
  logic signed [ACC_W-1:0] s1;
  logic signed [ACC_W-1:0] s2;
  logic signed [ACC_W-1:0] s3;
  logic signed [ACC_W-1:0] t20;
  logic signed [ACC_W-1:0] t13;
  logic signed [ACC_W-1:0] t6;

  // Sign-extend and pair up symmetric neighbours.
  always_comb begin
    e_c = {{(ACC_W-X_W){x_c[X_W-1]}}, x_c};
    s1  = {{(ACC_W-X_W){x_m1[X_W-1]}}, x_m1} + {{(ACC_W-X_W){x_p1[X_W-1]}}, x_p1};
    s2  = {{(ACC_W-X_W){x_m2[X_W-1]}}, x_m2} + {{(ACC_W-X_W){x_p2[X_W-1]}}, x_p2};
    s3  = {{(ACC_W-X_W){x_m3[X_W-1]}}, x_m3} + {{(ACC_W-X_W){x_p3[X_W-1]}}, x_p3};
  end

  // 20x = 16x + 4x, 13x = 8x + 4x + x, 6x = 4x + 2x; the signs of the
  // band (-13 and -1) are applied in the final sum.
  always_comb begin
    t20     = (e_c <<< 4) + (e_c <<< 2);
    t13     = (s1 <<< 3) + (s1 <<< 2) + s1;
    t6      = (s2 <<< 2) + (s2 <<< 1);
    row_sum = t20 - t13 + t6 - s3;
  end

endmodule

// File: rtl/gsim_residual_chk.sv
// gsim_residual_chk: collects the right-hand side b and the GSIM
// solution x, then streams the residual r = M*x - b one row per cycle
// and reports whether every |r[i]| stays within TOL.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   in_en, b_in     : b element strobe / signed 16-bit integer value
//   x_valid, x_in   : x element strobe / signed Q16.16 value
//   out_valid,r_out : residual strobe / signed Q16.16, 40-bit
//   done, pass      : one-cycle completion pulse and its verdict
module gsim_residual_chk
  import gsim_pkg::*;
#(
  parameter logic [31:0] TOL = 32'h0000_0100
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_en,
  input  logic [B_W-1:0] b_in,
  input  logic           x_valid,
  input  logic [X_W-1:0] x_in,
  output logic           out_valid,
  output logic [R_W-1:0] r_out,
  output logic           done,
  output logic           pass
);

  state_t state;
  logic [4:0] bcnt;
  logic [4:0] xcnt;
  logic [3:0] k;
  logic       fail;

  logic [B_W-1:0] b_mem [N];
  logic [X_W-1:0] x_mem [N];

  logic       b_take;
  logic       x_take;
  logic [4:0] bcnt_nxt;
  logic [4:0] xcnt_nxt;

  logic signed [X_W-1:0]   win [7];
  logic signed [ACC_W-1:0] row_sum;
  logic signed [ACC_W-1:0] b_align;
  logic signed [ACC_W-1:0] row_res;
  logic [B_W-1:0]          b_cur;
  logic                    row_bad;

  // A strobe is taken only while collecting and only until its buffer
  // is full, so late strobes never overwrite stored data.
  assign b_take   = (state == COLLECT) && in_en && !bcnt[4];
  assign x_take   = (state == COLLECT) && x_valid && !xcnt[4];
  assign bcnt_nxt = bcnt + {4'd0, b_take};
  assign xcnt_nxt = xcnt + {4'd0, x_take};

  // Operand storage is deliberately left out of reset; stale contents
  // are always overwritten before the next calculation.
  always_ff @(posedge clk) begin
    if (b_take) b_mem[bcnt[3:0]] <= b_in;
    if (x_take) x_mem[xcnt[3:0]] <= x_in;
  end

  // Gather x[k-3..k+3] for the current row, zero outside the matrix.
  always_comb begin
    int idx;
    for (int d = 0; d < 7; d++) begin
      idx    = int'(k) + d - 3;
      win[d] = '0;
      if (idx >= 0 && idx < N) win[d] = x_mem[idx[3:0]];
    end
  end

  gsim_band_row u_row (
    .x_m3   (win[0]),
    .x_m2   (win[1]),
    .x_m1   (win[2]),
    .x_c    (win[3]),
    .x_p1   (win[4]),
    .x_p2   (win[5]),
    .x_p3   (win[6]),
    .row_sum(row_sum)
  );

  // b is an integer; move it to Q16.16 before subtracting.
  always_comb begin
    b_cur   = b_mem[k];
    b_align = {{(ACC_W-B_W-FRAC){b_cur[B_W-1]}}, b_cur, {FRAC{1'b0}}};
    row_res = row_sum - b_align;
    row_bad = exceeds_tol(row_res, TOL);
  end

  // Control: collect both streams, compute 16 rows, then report. The
  // verdict for the last row is folded in directly so that pass is
  // ready in the same cycle as done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= COLLECT;
      bcnt      <= '0;
      xcnt      <= '0;
      k         <= '0;
      fail      <= 1'b0;
      out_valid <= 1'b0;
      r_out     <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      unique case (state)
        COLLECT: begin
          bcnt <= bcnt_nxt;
          xcnt <= xcnt_nxt;
          if (bcnt_nxt == 5'd16 && xcnt_nxt == 5'd16) begin
            state <= CALC;
            k     <= '0;
            fail  <= 1'b0;
          end
        end
        CALC: begin
          out_valid <= 1'b1;
          r_out     <= {row_res[ACC_W-1], row_res};
          if (row_bad) fail <= 1'b1;
          k <= k + 4'd1;
          if (k == 4'd15) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= ~(fail | row_bad);
          end
        end
        DONE: begin
          state <= COLLECT;
          bcnt  <= '0;
          xcnt  <= '0;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_residual_chk.sv
// tb_gsim_residual_chk: scoreboard bench for gsim_residual_chk.
// Expected residuals and verdicts come from an integer model of the
// banded matrix and are queued when a data set is loaded; a monitor
// pops and compares them whenever the DUT reports a result.
module tb_gsim_residual_chk;
  import gsim_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [15:0] b_in;
  logic        x_valid;
  logic [31:0] x_in;
  logic        out_valid;
  logic [39:0] r_out;
  logic        done;
  logic        pass;

  int total = 0;
  int bad   = 0;

  longint exp_r_q[$];
  bit     exp_pass_q[$];
  int     rows_seen;
  longint last_r;
  longint mon_e;
  logic [39:0] mon_ev;
  bit     mon_p;

  logic signed [15:0] cur_b [16];
  logic signed [31:0] cur_x [16];

  gsim_residual_chk #(.TOL(32'h0000_0100)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_en    (in_en),
    .b_in     (b_in),
    .x_valid  (x_valid),
    .x_in     (x_in),
    .out_valid(out_valid),
    .r_out    (r_out),
    .done     (done),
    .pass     (pass)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint coef(input int d);
    case (d)
      0: return longint'(COEF_D);
      1: return longint'(COEF_1);
      2: return longint'(COEF_2);
      3: return longint'(COEF_3);
      default: return 0;
    endcase
  endfunction

  task automatic check1(input string tag, input logic [39:0] got, input logic [39:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Model: r[k] = sum M[k][j]*x[j] - b[k]*2^16, verdict all |r| <= 256.
  task automatic push_expected();
    bit ok = 1'b1;
    for (int kk = 0; kk < 16; kk++) begin
      longint acc = 0;
      longint r;
      for (int j = kk - 3; j <= kk + 3; j++)
        if (j >= 0 && j < 16)
          acc += coef((j > kk) ? j - kk : kk - j) * longint'(cur_x[j]);
      r = acc - longint'(cur_b[kk]) * 65536;
      exp_r_q.push_back(r);
      if (r > 256 || r < -256) ok = 1'b0;
      last_r = r;
    end
    exp_pass_q.push_back(ok);
  endtask

  // Monitor: every result the DUT produces must match the queue head.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (out_valid === 1'b1) begin
        total++;
        assert (exp_r_q.size() > 0) else begin
          bad++;
          $error("[TB] FAIL unexpected_out_valid: got 1 want 0");
        end
        if (exp_r_q.size() > 0) begin
          mon_e  = exp_r_q.pop_front();
          mon_ev = mon_e[39:0];
          total++;
          assert (r_out === mon_ev) else begin
            bad++;
            $error("[TB] FAIL residual_row%0d: got %h want %h", rows_seen, r_out, mon_ev);
          end
          rows_seen++;
        end
      end
      if (done === 1'b1) begin
        total++;
        assert (exp_pass_q.size() > 0) else begin
          bad++;
          $error("[TB] FAIL unexpected_done: got 1 want 0");
        end
        if (exp_pass_q.size() > 0) begin
          mon_p = exp_pass_q.pop_front();
          total++;
          assert (pass === mon_p) else begin
            bad++;
            $error("[TB] FAIL verdict: got %b want %b", pass, mon_p);
          end
        end
      end
    end
  end

  // mode 0: both streams together; 1: all b, extra b strobes, then x;
  // 2: random gaps on both, extra b strobes while x is still pending.
  task automatic applyStimulus(input int mode, input int extra);
    int bi = 0;
    int xi = 0;
    int ex = extra;
    while (bi < 16 || xi < 16) begin
      @(posedge clk); #1;
      in_en = 1'b0;
      x_valid = 1'b0;
      case (mode)
        0: begin
          in_en = 1'b1; b_in = cur_b[bi]; bi++;
          x_valid = 1'b1; x_in = cur_x[xi]; xi++;
        end
        1: begin
          if (bi < 16) begin
            in_en = 1'b1; b_in = cur_b[bi]; bi++;
          end else if (ex > 0) begin
            in_en = 1'b1; b_in = 16'h7fff; ex--;
          end else begin
            x_valid = 1'b1; x_in = cur_x[xi]; xi++;
          end
        end
        default: begin
          if (bi < 16) begin
            if ($urandom_range(1, 0) == 1) begin
              in_en = 1'b1; b_in = cur_b[bi]; bi++;
            end
          end else if (ex > 0) begin
            in_en = 1'b1; b_in = 16'h8001; ex--;
          end
          if (xi < 16 && $urandom_range(3, 0) == 0) begin
            x_valid = 1'b1; x_in = cur_x[xi]; xi++;
          end
        end
      endcase
    end
    @(posedge clk); #1;
    in_en = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic checkOutput(input bit hold);
    int n = 0;
    bit got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    check1("done_seen", {39'd0, got}, 40'd1);
    #1;
    check1("scoreboard_drained", 40'(exp_r_q.size() + exp_pass_q.size()), 40'd0);
    if (hold) begin
      @(negedge clk);
      check1("idle_out_valid", {39'd0, out_valid}, 40'd0);
      check1("idle_done", {39'd0, done}, 40'd0);
      check1("r_out_hold", r_out, last_r[39:0]);
    end
  endtask

  // Load a set, confirm CALC begins on the completing edge (first
  // out_valid two negedges later), then wait for the verdict.
  task automatic run_set(input int mode, input int extra, input bit hold);
    int n = 0;
    rows_seen = 0;
    push_expected();
    applyStimulus(mode, extra);
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 10);
    check1("calc_start_latency", 40'(n), 40'd2);
    checkOutput(hold);
  endtask

  task automatic set_unit();
    for (int i = 0; i < 16; i++) begin
      cur_x[i] = 32'sh0001_0000;
      if (i == 0 || i == 15)      cur_b[i] = 16'sd12;
      else if (i == 1 || i == 14) cur_b[i] = -16'sd1;
      else if (i == 2 || i == 13) cur_b[i] = 16'sd5;
      else                        cur_b[i] = 16'sd4;
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) begin
      cur_b[i] = 16'($urandom);
      cur_x[i] = 32'($urandom);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; in_en = 1'b0; x_valid = 1'b0; b_in = '0; x_in = '0;
    repeat (2) @(negedge clk);
    check1("reset_out_valid", {39'd0, out_valid}, 40'd0);
    check1("reset_done", {39'd0, done}, 40'd0);
    check1("reset_pass", {39'd0, pass}, 40'd0);
    check1("reset_r_out", r_out, 40'd0);
    reset = 1'b0;

    $display("[TB] consistent system, streams together");
    set_unit();
    run_set(0, 0, 1'b1);

    $display("[TB] x zero, b one, b before x with extra b");
    for (int i = 0; i < 16; i++) begin
      cur_x[i] = '0;
      cur_b[i] = 16'sd1;
    end
    run_set(1, 3, 1'b1);

    $display("[TB] consistent system, random gaps with extra b");
    set_unit();
    run_set(2, 3, 1'b1);

    $display("[TB] single-row error above and below tolerance");
    set_unit();
    cur_x[7] = 32'sh0001_0200;
    run_set(0, 0, 1'b1);
    cur_x[7] = 32'sh0001_0008;
    run_set(2, 0, 1'b1);

    $display("[TB] reset during calculation");
    set_random();
    rows_seen = 0;
    push_expected();
    applyStimulus(0, 0);
    n = 0;
    while (rows_seen < 8 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check1("reached_row8", 40'(rows_seen), 40'd8);
    #2 reset = 1'b1;
    #1;
    check1("midcalc_out_valid", {39'd0, out_valid}, 40'd0);
    check1("midcalc_done", {39'd0, done}, 40'd0);
    check1("midcalc_r_out", r_out, 40'd0);
    exp_r_q.delete();
    exp_pass_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    set_random();
    run_set(2, 0, 1'b1);

    $display("[TB] back-to-back sets");
    set_random();
    cur_x[0] = 32'sh7fff_0000;
    run_set(0, 0, 1'b0);
    set_unit();
    run_set(1, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
